// File: rtl/prod_accum_pkg.sv
// prod_accum shared types and default widths.
// Optional saturation is selected by PROD_ACCUM_SAT_EN.
package prod_accum_pkg;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 40;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

endpackage

// File: rtl/prod_accum_acc_add.sv
// Wide unsigned adder with carry out.
// PROD_ACCUM_SAT_EN clamps the sum to all-ones on carry.
module acc_add #(
  parameter int W = 40
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign carry = full[W];

`ifdef PROD_ACCUM_SAT_EN
  assign sum = full[W] ? {W{1'b1}} : full[W-1:0];
`else
  assign sum = full[W-1:0];
`endif

endmodule

// File: rtl/prod_accum.sv
// Burst accumulator for multiplier products with valid/ready result.
// PROD_ACCUM_SAT_EN selects saturating instead of wrapping sums.
import prod_accum_pkg::*;

module prod_accum #(
  parameter int ACC_W = prod_accum_pkg::ACC_W,
  parameter int CNT_W = prod_accum_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] product,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              ovf_out,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t state_q, state_d;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic             accept;

  assign prod_ext = ACC_W'(product);
  assign accept   = in_valid && in_ready;

  acc_add #(
    .W(ACC_W)
  ) u_add (
    .a    (acc_q),
    .b    (prod_ext),
    .sum  (sum),
    .carry(carry)
  );

  // in_ready decodes only the state register; no path from out_ready
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign acc_out   = acc_q;
  assign cnt_out   = cnt_q;
  assign ovf_out   = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = prod_ext;
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? HOLD : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_d = sum;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          ovf_d = ovf_q | carry;
          if (in_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum, built with ACC_W=33 to reach overflow.
// Expected overflow result follows PROD_ACCUM_SAT_EN.
module tb_prod_accum;

  localparam int AW = 33;
  localparam int CW = 8;

  typedef struct {
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          ovf;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   product = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [AW-1:0] acc_out;
  logic [CW-1:0] cnt_out;
  logic          ovf_out;
  logic          out_valid;
  logic          out_ready = 1'b1;

  int   tests = 0;
  int   fails = 0;
  res_t sb[$];

  prod_accum #(
    .ACC_W(AW),
    .CNT_W(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .product  (product),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .acc_out  (acc_out),
    .cnt_out  (cnt_out),
    .ovf_out  (ovf_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_res(input logic [AW-1:0] a, input logic [CW-1:0] c,
                            input logic o);
    res_t r;
    r.acc = a;
    r.cnt = c;
    r.ovf = o;
    sb.push_back(r);
  endtask

  task automatic send(input logic [31:0] p, input logic last);
    in_valid = 1'b1;
    product  = p;
    in_last  = last;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // monitor: a take happens on the edge after a negedge with valid&ready
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      res_t e;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL result: unexpected acc=0x%0h cnt=%0d ovf=%0b",
                 acc_out, cnt_out, ovf_out);
      end else begin
        e = sb.pop_front();
        if (acc_out !== e.acc || cnt_out !== e.cnt || ovf_out !== e.ovf) begin
          fails++;
          $display("FAIL result: got acc=0x%0h cnt=%0d ovf=%0b want acc=0x%0h cnt=%0d ovf=%0b",
                   acc_out, cnt_out, ovf_out, e.acc, e.cnt, e.ovf);
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] ovf_exp;
`ifdef PROD_ACCUM_SAT_EN
    ovf_exp = 33'h1_FFFF_FFFF;
`else
    ovf_exp = 33'h0_0000_0000;
`endif

    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_acc", 64'(acc_out), 64'd0);
    chk("rst_cnt", 64'(cnt_out), 64'd0);
    chk("rst_ovf", 64'(ovf_out), 64'd0);
    step();
    rst = 1'b0;
    step();

    // single full-scale term
    expect_res(33'h0_FFFF_FFFF, 8'd1, 1'b0);
    send(32'hFFFF_FFFF, 1'b1);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_in_ready_hold", 64'(in_ready), 64'd0);
    step();
    chk("single_in_ready_after", 64'(in_ready), 64'd1);

    // burst of 4, back-to-back
    expect_res(33'd10, 8'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("burst_in_ready", 64'(in_ready), 64'd1);
      send(32'(i + 1), i == 3);
    end
    step();

    // backpressure in HOLD
    out_ready = 1'b0;
    expect_res(33'd110, 8'd2, 1'b0);
    send(32'd50, 1'b0);
    send(32'd60, 1'b1);
    in_valid = 1'b1;
    in_last  = 1'b1;
    product  = 32'd999;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_acc", 64'(acc_out), 64'd110);
      chk("bp_cnt", 64'(cnt_out), 64'd2);
      step();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_idle", 64'(out_valid), 64'd0);
    expect_res(33'd7, 8'd1, 1'b0);
    send(32'd7, 1'b1);
    step();

    // carry out of the top accumulator bit
    expect_res(ovf_exp, 8'd3, 1'b1);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h2, 1'b1);
    step();

    // asynchronous reset mid-burst discards partial sum
    send(32'd7, 1'b0);
    send(32'd9, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_acc", 64'(acc_out), 64'd0);
    chk("mid_rst_cnt", 64'(cnt_out), 64'd0);
    chk("mid_rst_ovf", 64'(ovf_out), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    step();
    rst = 1'b0;
    expect_res(33'd5, 8'd1, 1'b0);
    send(32'd5, 1'b1);
    step();

    // gaps inside a burst
    expect_res(33'd300, 8'd2, 1'b0);
    send(32'd100, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("gap_in_ready", 64'(in_ready), 64'd1);
    chk("gap_valid", 64'(out_valid), 64'd0);
    send(32'd200, 1'b1);
    step();

    // term counter saturates at 255
    expect_res(33'd260, 8'd255, 1'b0);
    for (int i = 0; i < 260; i++) begin
      send(32'd1, i == 259);
    end
    step();

    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
